// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: requester side (drives req/mode); slave: arbiter side (drives grants).
interface rr_priority_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             mode;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, mode,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with fixed-priority (highest index wins) or round-robin policy.
// The grant is registered and one-hot, and its binary index drives the resource mux.
// Grants are never preempted. A grant can be force-released after MAX_HOLD cycles.
// Each release is followed by at least one idle cycle before the next grant.
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  rr_priority_arbiter_if.slave bus
);

  // Hold counter needs to reach MAX_HOLD; keep at least one bit so MAX_HOLD=0 still builds.
  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HC_MAX     = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     gnt_reg, gnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] last_idx_reg, last_idx_next;
  logic [HC_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic             timeout_reg, timeout_next;

  logic [N-1:0]     below_last;
  logic [N-1:0]     rr_masked;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  logic             owner_req;
  logic             at_limit;

  // Highest set bit of a request vector (0 when empty; callers only use it when non-empty).
  function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Round robin searches down from last_idx-1 first, so it first looks only at indices below
  // last_idx. If none of those requests are set, it wraps and takes the highest request
  // overall. That wrap lands in [last_idx, N-1], which leaves last_idx itself as the lowest priority.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign below_last[gi] = (IDX_W'(gi) < last_idx_reg);
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  assign rr_masked = bus.req & below_last;

  // Winner selection for the next IDLE-to-BUSY decision.
  always_comb begin
    win_idx = highest_set(bus.req);
    if (bus.mode && (rr_masked != '0)) begin
      win_idx = highest_set(rr_masked);
    end
  end

  // The granted line is selected with the one-hot grant, which avoids a variable bit-select.
  assign owner_req = |(bus.req & gnt_reg);
  assign at_limit  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT);

  // Next-state and registered-output logic of the IDLE/BUSY controller.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    idx_next      = idx_reg;
    last_idx_next = last_idx_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req != '0) begin
          state_next    = BUSY;
          gnt_next      = win_onehot;
          idx_next      = win_idx;
          hold_cnt_next = HC_W'(1);
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // A normal release takes precedence over a timeout on the same edge.
          state_next    = IDLE;
          gnt_next      = '0;
          idx_next      = '0;
          last_idx_next = idx_reg;
          hold_cnt_next = '0;
        end else if (at_limit) begin
          state_next    = IDLE;
          gnt_next      = '0;
          idx_next      = '0;
          last_idx_next = idx_reg;
          hold_cnt_next = '0;
          timeout_next  = 1'b1;
        end else if (hold_cnt_reg != HC_MAX) begin
          // With no limit, the counter saturates instead of wrapping.
          hold_cnt_next = hold_cnt_reg + HC_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        idx_next      = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything, even mid-grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      idx_reg      <= idx_next;
      last_idx_reg <= last_idx_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = idx_reg;
  assign bus.gnt_valid = |gnt_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Arbitrates one shared resource among N requesters and produces a registered one-hot grant plus its binary index.
- Two selectable policies: fixed priority, where the highest index wins (bit N-1 on top, same ordering as our 8:3 priority encoder), and round robin with a rotating last-granted pointer.
- Sits in front of any shared datapath port; the grant index drives the resource mux select directly.

Parameters:
- N, 8, number of requesters (2..16).
- IDX_W, 3, width of the index; must satisfy 2**IDX_W >= N.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  request lines, level-sensitive; a requester holds its line high for as long as it needs the resource.
- mode  input  1  0 = fixed priority, 1 = round robin; sampled only in IDLE.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of the granted requester; 0 when no grant.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.
- timeout  output  1  single-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, any state, including mid-grant):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State=IDLE, hold_cnt=0, last_idx=0.
- State IDLE:
  - If req!=0 at a clock edge, the winner is registered at that edge and the FSM enters BUSY. Latency is 1 cycle: req sampled at edge k gives gnt visible after edge k.
  - If req==0, all outputs stay 0.
- Winner selection:
  - Fixed mode (mode=0): highest set index of req.
  - Round-robin mode (mode=1): search descending, starting at (last_idx-1) mod N and wrapping from 0 to N-1. The first set bit wins, so the last-granted requester has the lowest priority.
  - After reset last_idx=0, so the search starts at N-1 and round robin matches fixed priority for the first grant.
- State BUSY:
  - gnt, gnt_idx and gnt_valid are held constant.
  - No preemption: changes on other req lines are ignored.
  - hold_cnt counts grant cycles; it equals 1 in the first grant cycle.
- Normal release: when req[gnt_idx]=0 is sampled, gnt clears at that edge, last_idx<=gnt_idx, and the FSM returns to IDLE.
- Forced release (MAX_HOLD>0):
  - Occurs when hold_cnt==MAX_HOLD and req[gnt_idx] is still 1.
  - At that edge: gnt clears, timeout=1 for exactly one cycle, last_idx<=gnt_idx, FSM returns to IDLE.
  - If the requester drops its line on the same edge that the timeout would fire, treat it as a normal release with no timeout pulse.
- Grant spacing: there is always at least one IDLE cycle with gnt=0 between consecutive grants, giving the resource mux a clean turnaround.
- Grant length: a grant lasts at most MAX_HOLD cycles. With MAX_HOLD=0 the grant is unbounded and hold_cnt saturates at its maximum with no wrap.
- Re-grant: in fixed mode a timed-out requester may win again immediately after the IDLE cycle if it is still the highest set index.
- mode changes take effect at the next IDLE-to-BUSY decision.
- Widths: hold_cnt is clog2(MAX_HOLD+1) bits, minimum 1. gnt_idx is zero-extended to IDX_W.

Test Plan:
- Reset: drive rst=1 while gnt=8'h10 → gnt=0, gnt_idx=0, gnt_valid=0, timeout=0 immediately, without waiting for a clock edge. Release rst with req=0 → all outputs stay 0.
- Fixed mode: req=8'b0101_0010 → one cycle later gnt=8'h40, gnt_idx=6. Drop req[6] → gnt=0 for one cycle, then gnt=8'h10, gnt_idx=4.
- Round robin with MAX_HOLD=4, req=8'hFF held → grant order 7,6,5,4,3,2,1,0,7. Each grant is high exactly 4 cycles and followed by 1 zero cycle; timeout pulses once per grant.
- Round-robin wrap: after a grant to 1 ends, req=8'b1000_0001 → gnt_idx=0 wins (search starts at 0). The next decision gives gnt_idx=7.
- No preemption: grant active on 2, raise req[7] → gnt stays 8'h04 until req[2] drops; 7 is granted after the one-cycle gap.
- MAX_HOLD=0: hold req[3] alone for 100 cycles → gnt=8'h08 throughout, timeout never asserts.
